// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath (operands, accumulator, bit counter) for the Load/Sh/Ad control FSM.
// Define MULT_SIGNED_EN for two's-complement operands (arithmetic shift, final-bit subtract).
module mult_datapath #(
    parameter int N = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [N-1:0]   Multiplicand,
    input  logic [N-1:0]   Multiplier,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
    output logic           K,
    output logic           M,
    output logic [2*N-1:0] Product,
    output logic           Done,
    output logic           Busy
);
    localparam int CW = $clog2(N + 1);

    logic [2*N:0]  acc;
    logic [N-1:0]  mcnd;
    logic [CW-1:0] cnt;
    logic          pend, busy, skip, done;

    logic [N:0]    upper, addend, sum;
    logic [2*N:0]  acc_sh;
    logic          last, msb_in;

    // Sum feeds the shifter directly so an Ad+Sh cycle adds then shifts.
    always_comb begin
        upper = acc[2*N:N];
        last  = (cnt == CW'(1));
`ifdef MULT_SIGNED_EN
        addend = {mcnd[N-1], mcnd};
        sum    = upper;
        if (Ad) sum = last ? upper - addend : upper + addend;
        msb_in = sum[N];
`else
        addend = {1'b0, mcnd};
        sum    = Ad ? upper + addend : upper;
        msb_in = 1'b0;
`endif
        acc_sh = {msb_in, sum, acc[N-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            acc  <= '0;
            mcnd <= '0;
            cnt  <= '0;
            pend <= 1'b0;
            busy <= 1'b0;
            skip <= 1'b0;
            done <= 1'b0;
        end else if (Load) begin
            acc  <= {{(N+1){1'b0}}, Multiplier};
            mcnd <= Multiplicand;
            cnt  <= CW'(N);
            busy <= 1'b1;
            skip <= 1'b1;
            pend <= 1'b0;
            done <= 1'b0;
        end else begin
            if (Start && !busy && !pend) pend <= 1'b1;
            if (busy) begin
                // First Sh after Load is the FSM's dummy shift.
                if (skip) begin
                    if (Sh) skip <= 1'b0;
                end else if (Sh) begin
                    acc <= acc_sh;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end else if (Ad) begin
                    acc <= {sum, acc[N-1:0]};
                end
            end
        end
    end

    assign K       = pend;
    assign M       = acc[0];
    assign Product = acc[2*N-1:0];
    assign Done    = done;
    assign Busy    = busy;
endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath; the bench plays the control FSM role.
module tb_mult_datapath;
    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           Start = 1'b0;
    logic           Load = 1'b0;
    logic           Sh = 1'b0;
    logic           Ad = 1'b0;
    logic [N-1:0]   Multiplicand = '0;
    logic [N-1:0]   Multiplier = '0;
    logic           K, M, Done, Busy;
    logic [2*N-1:0] Product;

    int total = 0;
    int bad = 0;
    logic [2*N-1:0] sb[$];

    mult_datapath #(.N(N)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Load(Load), .Sh(Sh), .Ad(Ad),
        .K(K), .M(M), .Product(Product), .Done(Done), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MULT_SIGNED_EN
        logic [2*N-1:0] sa, sbv;
        sa  = {{N{a[N-1]}}, a};
        sbv = {{N{b[N-1]}}, b};
        model = sa * sbv;
`else
        model = {{N{1'b0}}, a} * {{N{1'b0}}, b};
`endif
    endfunction

    // One full operation: optional Start/K handshake, Load, dummy Sh, N (Ad=M, Sh) pairs.
    task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit use_start, input bit start_mid);
        logic [2*N-1:0] e;
        if (use_start) begin
            Start = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
            total++;
            if (K !== 1'b1) begin bad++; $display("FAIL k_pend: got %b want 1", K); end
        end
        Multiplicand = a; Multiplier = b; Load = 1'b1;
        sb.push_back(model(a, b));
        @(negedge Clk);
        Load = 1'b0; Sh = 1'b1;
        total++;
        if ({Busy, Done, K} !== 3'b100) begin
            bad++; $display("FAIL after_load: got busy/done/k=%b want 100", {Busy, Done, K});
        end
        for (int i = 0; i < N; i++) begin
            @(negedge Clk);
            Sh = 1'b0;
            total++;
            if (M !== b[i]) begin bad++; $display("FAIL m_bit%0d: got %b want %b", i, M, b[i]); end
            Ad = M;
            if (start_mid && i == 1) Start = 1'b1;
            @(negedge Clk);
            if (start_mid && i == 1) begin
                Start = 1'b0;
                total++;
                if (K !== 1'b0) begin bad++; $display("FAIL start_busy: got K=%b want 0", K); end
            end
            Ad = 1'b0; Sh = 1'b1;
            if (i == N - 1) begin
                total++;
                if (Done !== 1'b0) begin bad++; $display("FAIL done_early: got %b want 0", Done); end
            end
        end
        @(negedge Clk);
        Sh = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if ({Done, Busy, Product} !== {2'b10, e}) begin
                bad++;
                $display("FAIL result %0d*%0d: got done=%b busy=%b prod=%0h want done=1 busy=0 prod=%0h",
                         a, b, Done, Busy, Product, e);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            Load = 1'($urandom); Sh = 1'($urandom); Ad = 1'($urandom); Start = 1'($urandom);
            @(negedge Clk);
            total++;
            if ({K, M, Done, Busy, Product} !== '0) begin
                bad++;
                $display("FAIL reset%0d: got k=%b m=%b done=%b busy=%b prod=%0h want all 0",
                         i, K, M, Done, Busy, Product);
            end
        end
        Load = 0; Sh = 0; Ad = 0; Start = 0;
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        do_mult(4'd13, 4'd11, 1'b1, 1'b0);
        total++;
        if (Product !== 8'd143) begin bad++; $display("FAIL basic_143: got %0d want 143", Product); end
        do_mult(4'd15, 4'd15, 1'b0, 1'b0);
        total++;
        if (Product !== 8'd225) begin bad++; $display("FAIL carry_225: got %0d want 225", Product); end
    endtask

    task automatic test_ignore();
        logic [2*N-1:0] held;
        do_mult(4'd6, 4'd7, 1'b1, 1'b1);
        held = Product;
        Ad = 1'b1; Sh = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if ({Product, Done, Busy, K} !== {held, 3'b100}) begin
                bad++;
                $display("FAIL idle_adsh%0d: got prod=%0h done=%b busy=%b k=%b want prod=%0h done=1 busy=0 k=0",
                         i, Product, Done, Busy, K, held);
            end
        end
        Ad = 1'b0; Sh = 1'b0;
    endtask

    task automatic test_mid_reset();
        Multiplicand = 4'd13; Multiplier = 4'd11; Load = 1'b1;
        @(negedge Clk); Load = 1'b0; Sh = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); Sh = 1'b0; Ad = M;
            @(negedge Clk); Ad = 1'b0; Sh = 1'b1;
        end
        @(negedge Clk); Sh = 1'b0;
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if ({K, M, Done, Busy, Product} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got k=%b m=%b done=%b busy=%b prod=%0h want all 0",
                     K, M, Done, Busy, Product);
        end
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_zero_and_restart();
        do_mult(4'd9, 4'd0, 1'b1, 1'b0);
        total++;
        if (Product !== 8'd0) begin bad++; $display("FAIL zero: got %0d want 0", Product); end
        // Load while busy abandons the first operation.
        Multiplicand = 4'd3; Multiplier = 4'd5; Load = 1'b1;
        @(negedge Clk); Load = 1'b0; Sh = 1'b1;
        @(negedge Clk); Sh = 1'b0; Ad = M;
        @(negedge Clk); Ad = 1'b0; Sh = 1'b1;
        @(negedge Clk); Sh = 1'b0;
        do_mult(4'd10, 4'd12, 1'b0, 1'b0);
        total++;
        if (Product !== 8'd120) begin bad++; $display("FAIL restart_120: got %0d want 120", Product); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            do_mult(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        do_mult(4'b1101, 4'd5, 1'b1, 1'b0);
        total++;
        if (Product !== 8'hF1) begin bad++; $display("FAIL signed_m15: got %0h want f1", Product); end
        do_mult(4'b1000, 4'b1000, 1'b1, 1'b0);
        total++;
        if (Product !== 8'd64) begin bad++; $display("FAIL signed_64: got %0h want 40", Product); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MULT_SIGNED_EN
        test_signed();
`else
        test_basic();
        test_zero_and_restart();
`endif
        test_ignore();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
